fifo_reader: RTL and testbench
==============================

Name: fifo_reader

Overview:
Read-side drain engine for the multi-bit FIFO.
- Watches the FIFO `empty` flag, issues `rd` pulses, and captures `dout` after a fixed read latency.
- Presents the words downstream on a valid/ready stream.
- Keeps a small credit-checked holding buffer, so downstream back-pressure never causes an over-read and a ready sink gets one word per cycle.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and stream data.
- RD_LATENCY, 1, cycles from `fifo_rd` sampled high to valid `fifo_dout`; legal range 1..3.
- BUF_DEPTH, 3, holding-buffer entries; must be >= RD_LATENCY+2 for full throughput.

Ports:
- clk, in, 1, single clock; all logic on the rising edge.
- reset, in, 1, synchronous, active-high reset.
- fifo_dout, in, DATA_WIDTH, FIFO read data; valid RD_LATENCY cycles after a read.
- fifo_empty, in, 1, FIFO empty flag.
- fifo_rd, out, 1, read strobe to the FIFO.
- m_data, out, DATA_WIDTH, stream data (head of holding buffer).
- m_valid, out, 1, stream data valid.
- m_ready, in, 1, downstream accepts `m_data` this cycle.
- words_read, out, 16, count of words delivered on the stream; wraps modulo 2^16.
- idle, out, 1, high when the buffer is empty, nothing is in flight, and `fifo_empty`=1.

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: `m_valid`=0, `m_data`=0, `words_read`=0, `idle`=1.
  - Internal: buffer count=0, in-flight shift register cleared.
  - `fifo_rd`=0 in every cycle `reset`=1.
- Reset asserted mid-operation:
  - In-flight reads and buffered words are discarded.
  - This data loss is accepted; upstream resets the FIFO together with this block.
- Credit rule (combinational): fifo_rd = ~reset & ~fifo_empty & (count + inflight < BUF_DEPTH).
  - `inflight` is the popcount of an RD_LATENCY-deep shift register of past `fifo_rd`.
  - `m_ready` is not in the `fifo_rd` path; no combinational path from `m_ready` to `fifo_rd`.
- Capture: when the shift-register tail is 1, `fifo_dout` is written into the buffer at that edge.
- Latency: `fifo_rd` high in cycle N -> word captured at end of cycle N+RD_LATENCY -> `m_valid` high in cycle N+RD_LATENCY+1.
- Stream handshake:
  - `m_valid` = (count != 0), driven from a register.
  - A transfer occurs when `m_valid` & `m_ready`.
  - `m_data` holds stable while `m_valid`=1 and `m_ready`=0.
- Buffer:
  - Circular, head/tail pointers wrap at BUF_DEPTH (non-power-of-2 allowed).
  - Count update: count_next = count + capture - transfer.
  - Simultaneous capture and transfer leaves count unchanged, including at count=1.
- Overflow is impossible by the credit rule. Bench asserts count <= BUF_DEPTH at all times.
- Underflow protection: `fifo_rd` is never high while `fifo_empty`=1.
- `words_read` increments by 1 per transfer; 0xFFFF wraps to 0x0000.
- `idle` is registered and reflects the state after the current edge.
- Throughput: with `m_ready`=1 and a non-empty FIFO, one transfer per cycle in steady state.

Decomposition:
- Package `fifo_pkg`:
  - DATA_WIDTH default.
  - Function `clog2_min1` for pointer/count widths.
  - Localparam CNT_W = 16.
- Sub-module `reader_buf`:
  - Parameterised circular buffer: push, pop, data in/out, count, not-empty flag.
  - Reused later on the write side.
- Top level holds the credit logic, the in-flight shift register, and the `words_read` counter.

Test Plan:
1. Reset then idle:
   - Stimulus: `reset`=1 for 3 cycles with `fifo_empty`=0; then `fifo_empty`=1.
   - Required: `fifo_rd`=0 throughout reset; `m_valid`=0; `idle`=1; `words_read`=0.
2. Basic drain, RD_LATENCY=1:
   - Stimulus: FIFO model preloaded with 5,3,6,6; `m_ready`=1.
   - Required: `m_data` sequence 5,3,6,6 on consecutive cycles; first `m_valid` 2 cycles after first `fifo_rd`; `words_read`=4; `idle`=1 after.
3. Back-pressure:
   - Stimulus: preload 10 words; `m_ready`=0 for 8 cycles, then 1.
   - Required: exactly 3 `fifo_rd` pulses before stall; count peaks at 3; `m_data` holds the first word (5); no word lost or duplicated; all 10 delivered in order.
4. Empty boundary:
   - Stimulus: `fifo_empty` toggles every cycle while FIFO supplies 1,2,3.
   - Required: `fifo_rd` is never high with `fifo_empty`=1; output is 1,2,3 in order.
5. Reset mid-operation:
   - Stimulus: assert `reset` for 1 cycle while count=2 and inflight=1.
   - Required: next cycle `m_valid`=0, `words_read`=0; in-flight word is not captured.
6. Counter wrap and latency sweep:
   - Stimulus: force 65,537 transfers; repeat test 2 with RD_LATENCY=3, BUF_DEPTH=5.
   - Required: `words_read` wraps to 1; first `m_valid` 4 cycles after first `fifo_rd`; one word per cycle sustained.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths and sizing helper for the FIFO read/write engines
package fifo_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int CNT_W      = 16;

    // Minimum bits to index n values, never less than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/reader_buf.sv
// rtl/reader_buf.sv - circular holding buffer with count and registered not-empty flag
import fifo_pkg::*;

module reader_buf #(
    parameter int DW     = fifo_pkg::DATA_WIDTH,
    parameter int DEPTH  = 3,
    parameter int PTR_W  = clog2_min1(DEPTH),
    parameter int CNT_BW = clog2_min1(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DW-1:0]     push_data,
    input  logic              pop,
    output logic [DW-1:0]     pop_data,
    output logic [CNT_BW-1:0] count,
    output logic              not_empty
);

    logic [DW-1:0]     mem_q [DEPTH];
    logic [DW-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_BW-1:0] count_q, count_d;
    logic              not_empty_q, not_empty_d;
    logic              pop_eff;

    assign pop_eff = pop & not_empty_q;

    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        if (push) begin
            mem_d[tail_q] = push_data;
            tail_d = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + 1'b1;
        end
        if (pop_eff) begin
            head_d = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + 1'b1;
        end
        count_d     = count_q + CNT_BW'(push) - CNT_BW'(pop_eff);
        not_empty_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            not_empty_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            not_empty_q <= not_empty_d;
        end
    end

    assign pop_data  = mem_q[head_q];
    assign count     = count_q;
    assign not_empty = not_empty_q;

endmodule

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - credit-checked FIFO drain engine feeding a valid/ready stream
import fifo_pkg::*;

module fifo_reader #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_W-1:0]      words_read,
    output logic                  idle
);

    localparam int BCW = clog2_min1(BUF_DEPTH + 1);

    logic [RD_LATENCY-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0]      words_read_q, words_read_d;
    logic                  idle_q, idle_d;
    logic [BCW-1:0]        buf_count;
    logic                  capture;
    logic                  transfer;
    int                    inflight_cnt;
    int                    cnt_next;

    always_comb begin
        inflight_cnt = 0;
        for (int i = 0; i < RD_LATENCY; i++) inflight_cnt += int'(inflight_q[i]);
    end

    // Reserve a buffer slot for every read still in the FIFO pipeline;
    // m_ready stays out of this path on purpose.
    assign fifo_rd  = ~reset & ~fifo_empty & ((int'(buf_count) + inflight_cnt) < BUF_DEPTH);
    assign capture  = inflight_q[RD_LATENCY-1];
    assign transfer = m_valid & m_ready;

    always_comb begin
        inflight_d   = RD_LATENCY'({inflight_q, fifo_rd});
        words_read_d = words_read_q + CNT_W'(transfer);
        cnt_next     = int'(buf_count) + int'(capture) - int'(transfer);
        idle_d       = (cnt_next == 0) && (inflight_d == '0) && fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q   <= '0;
            words_read_q <= '0;
            idle_q       <= 1'b1;
        end else begin
            inflight_q   <= inflight_d;
            words_read_q <= words_read_d;
            idle_q       <= idle_d;
        end
    end

    reader_buf #(
        .DW    (DATA_WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .push_data (fifo_dout),
        .pop       (transfer),
        .pop_data  (m_data),
        .count     (buf_count),
        .not_empty (m_valid)
    );

    assign words_read = words_read_q;
    assign idle       = idle_q;

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - scoreboard bench for fifo_reader at read latencies 1 and 3
module tb_fifo_reader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, fifo_empty_a, fifo_rd_a, m_valid_a, m_ready_a, idle_a;
    logic [7:0]  fifo_dout_a, m_data_a;
    logic [15:0] words_read_a;
    logic        reset_b, fifo_empty_b, fifo_rd_b, m_valid_b, m_ready_b, idle_b;
    logic [7:0]  fifo_dout_b, m_data_b;
    logic [15:0] words_read_b;

    fifo_reader #(.DATA_WIDTH(8), .RD_LATENCY(1), .BUF_DEPTH(3)) u_a (
        .clk(clk), .reset(reset_a), .fifo_dout(fifo_dout_a), .fifo_empty(fifo_empty_a),
        .fifo_rd(fifo_rd_a), .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a),
        .words_read(words_read_a), .idle(idle_a)
    );

    fifo_reader #(.DATA_WIDTH(8), .RD_LATENCY(3), .BUF_DEPTH(5)) u_b (
        .clk(clk), .reset(reset_b), .fifo_dout(fifo_dout_b), .fifo_empty(fifo_empty_b),
        .fifo_rd(fifo_rd_b), .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
        .words_read(words_read_b), .idle(idle_b)
    );

    logic [7:0] qa[$], qb[$], expa[$], expb[$];
    logic [7:0] rd_word_a, rd_word_b;
    logic [7:0] dpb [3];
    bit         rst_a, rst_b, rdy_a, rdy_b, force_ne_a, gate_a;
    int         cyc, checks, errors;
    int         rd_cnt_a, rd_cnt_b;

    // One clock cycle: drive model outputs at negedge, then sample and score.
    task automatic step();
        logic [7:0] e;
        @(negedge clk);
        cyc++;
        fifo_dout_a  = rd_word_a;
        dpb[2]       = dpb[1];
        dpb[1]       = dpb[0];
        dpb[0]       = rd_word_b;
        fifo_dout_b  = dpb[2];
        reset_a      = rst_a;
        reset_b      = rst_b;
        fifo_empty_a = ((qa.size() == 0) && !force_ne_a) || gate_a;
        fifo_empty_b = (qb.size() == 0);
        m_ready_a    = rdy_a;
        m_ready_b    = rdy_b;
        #1;
        checks++;
        if (fifo_rd_a && (fifo_empty_a || reset_a)) begin
            errors++;
            $display("FAIL underflow_a cyc=%0d rd=%b empty=%b reset=%b required rd=0", cyc, fifo_rd_a, fifo_empty_a, reset_a);
        end
        checks++;
        if (fifo_rd_b && (fifo_empty_b || reset_b)) begin
            errors++;
            $display("FAIL underflow_b cyc=%0d rd=%b empty=%b reset=%b required rd=0", cyc, fifo_rd_b, fifo_empty_b, reset_b);
        end
        checks++;
        if (u_a.u_buf.count_q > 3 || u_b.u_buf.count_q > 5) begin
            errors++;
            $display("FAIL overflow cyc=%0d count_a=%0d count_b=%0d required <=3/<=5", cyc, u_a.u_buf.count_q, u_b.u_buf.count_q);
        end
        if (fifo_rd_a === 1'b1) begin
            rd_cnt_a++;
            if (qa.size() > 0) rd_word_a = qa.pop_front();
        end
        if (fifo_rd_b === 1'b1) begin
            rd_cnt_b++;
            if (qb.size() > 0) rd_word_b = qb.pop_front();
        end
        if (m_valid_a === 1'b1 && m_ready_a) begin
            checks++;
            if (expa.size() == 0) begin
                errors++;
                $display("FAIL extra_word_a cyc=%0d got=%0d required none", cyc, m_data_a);
            end else begin
                e = expa.pop_front();
                if (m_data_a !== e) begin
                    errors++;
                    $display("FAIL data_a cyc=%0d got=%0d required %0d", cyc, m_data_a, e);
                end
            end
        end
        if (m_valid_b === 1'b1 && m_ready_b) begin
            checks++;
            if (expb.size() == 0) begin
                errors++;
                $display("FAIL extra_word_b cyc=%0d got=%0d required none", cyc, m_data_b);
            end else begin
                e = expb.pop_front();
                if (m_data_b !== e) begin
                    errors++;
                    $display("FAIL data_b cyc=%0d got=%0d required %0d", cyc, m_data_b, e);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_a = 1; rst_b = 1; force_ne_a = 1;
        repeat (3) begin
            step();
            checks++;
            if (fifo_rd_a !== 1'b0 || fifo_rd_b !== 1'b0) begin
                errors++;
                $display("FAIL reset_rd got a=%b b=%b required 0", fifo_rd_a, fifo_rd_b);
            end
        end
        rst_a = 0; rst_b = 0; force_ne_a = 0;
        step();
        checks++;
        if (m_valid_a !== 1'b0 || idle_a !== 1'b1 || words_read_a !== 16'd0 || m_data_a !== 8'd0) begin
            errors++;
            $display("FAIL reset_state_a got valid=%b idle=%b words=%0d data=%0d required 0/1/0/0", m_valid_a, idle_a, words_read_a, m_data_a);
        end
        checks++;
        if (m_valid_b !== 1'b0 || idle_b !== 1'b1 || words_read_b !== 16'd0) begin
            errors++;
            $display("FAIL reset_state_b got valid=%b idle=%b words=%0d required 0/1/0", m_valid_b, idle_b, words_read_b);
        end
    endtask

    task automatic test_basic(input bit use_b, input int lat_exp, input int words_exp);
        int frd, fv, ftx, ltx, n;
        logic [7:0] vals [4];
        vals = '{8'd5, 8'd3, 8'd6, 8'd6};
        frd = -1; fv = -1; ftx = -1; ltx = -1; n = 0;
        for (int i = 0; i < 4; i++) begin
            if (use_b) begin qb.push_back(vals[i]); expb.push_back(vals[i]); end
            else       begin qa.push_back(vals[i]); expa.push_back(vals[i]); end
        end
        rdy_a = 1; rdy_b = 1;
        while (n < 40 && (use_b ? expb.size() : expa.size()) != 0) begin
            step();
            n++;
            if ((use_b ? fifo_rd_b : fifo_rd_a) && frd < 0) frd = cyc;
            if ((use_b ? m_valid_b : m_valid_a) && fv < 0) fv = cyc;
            if (use_b ? m_valid_b : m_valid_a) begin
                if (ftx < 0) ftx = cyc;
                ltx = cyc;
            end
        end
        repeat (3) step();
        checks++;
        if ((use_b ? expb.size() : expa.size()) != 0) begin
            errors++;
            $display("FAIL basic_timeout b=%0d left=%0d required 0", use_b, use_b ? expb.size() : expa.size());
        end
        checks++;
        if (fv - frd != lat_exp) begin
            errors++;
            $display("FAIL basic_latency b=%0d got=%0d required %0d", use_b, fv - frd, lat_exp);
        end
        checks++;
        if (ltx - ftx != 3) begin
            errors++;
            $display("FAIL basic_throughput b=%0d span=%0d required 3", use_b, ltx - ftx);
        end
        checks++;
        if ((use_b ? words_read_b : words_read_a) !== 16'(words_exp) || (use_b ? idle_b : idle_a) !== 1'b1) begin
            errors++;
            $display("FAIL basic_end b=%0d words=%0d idle=%b required %0d/1", use_b,
                     use_b ? words_read_b : words_read_a, use_b ? idle_b : idle_a, words_exp);
        end
    endtask

    task automatic test_backpressure();
        int r0, n;
        for (int i = 0; i < 10; i++) begin
            qa.push_back((i == 0) ? 8'd5 : 8'(10 + i));
            expa.push_back((i == 0) ? 8'd5 : 8'(10 + i));
        end
        rdy_a = 0;
        r0 = rd_cnt_a;
        repeat (8) step();
        checks++;
        if (rd_cnt_a - r0 != 3) begin
            errors++;
            $display("FAIL bp_reads got=%0d required 3", rd_cnt_a - r0);
        end
        checks++;
        if (u_a.u_buf.count_q !== 2'd3) begin
            errors++;
            $display("FAIL bp_count got=%0d required 3", u_a.u_buf.count_q);
        end
        checks++;
        if (m_valid_a !== 1'b1 || m_data_a !== 8'd5) begin
            errors++;
            $display("FAIL bp_hold got valid=%b data=%0d required 1/5", m_valid_a, m_data_a);
        end
        rdy_a = 1;
        n = 0;
        while (n < 40 && expa.size() != 0) begin step(); n++; end
        step();
        checks++;
        if (expa.size() != 0 || words_read_a !== 16'd14) begin
            errors++;
            $display("FAIL bp_drain left=%0d words=%0d required 0/14", expa.size(), words_read_a);
        end
    endtask

    task automatic test_empty_boundary();
        int n;
        for (int i = 1; i <= 3; i++) begin qa.push_back(8'(i)); expa.push_back(8'(i)); end
        rdy_a = 1;
        n = 0;
        while (n < 30 && expa.size() != 0) begin
            gate_a = ~gate_a;
            step();
            n++;
        end
        gate_a = 0;
        step();
        checks++;
        if (expa.size() != 0 || words_read_a !== 16'd17) begin
            errors++;
            $display("FAIL empty_drain left=%0d words=%0d required 0/17", expa.size(), words_read_a);
        end
    endtask

    task automatic test_reset_mid();
        int r0, n;
        for (int i = 0; i < 6; i++) begin qa.push_back(8'(20 + i)); expa.push_back(8'(20 + i)); end
        rdy_a = 0;
        r0 = rd_cnt_a;
        n = 0;
        while (n < 10 && rd_cnt_a - r0 < 3) begin step(); n++; end
        rst_a = 1;
        step();
        checks++;
        if (u_a.u_buf.count_q !== 2'd2 || u_a.inflight_q !== 1'b1) begin
            errors++;
            $display("FAIL midrst_setup count=%0d inflight=%b required 2/1", u_a.u_buf.count_q, u_a.inflight_q);
        end
        qa.delete();
        expa.delete();
        rst_a = 0;
        step();
        checks++;
        if (m_valid_a !== 1'b0 || words_read_a !== 16'd0 || idle_a !== 1'b1) begin
            errors++;
            $display("FAIL midrst_state valid=%b words=%0d idle=%b required 0/0/1", m_valid_a, words_read_a, idle_a);
        end
        step();
        checks++;
        if (m_valid_a !== 1'b0 || u_a.u_buf.count_q !== 2'd0) begin
            errors++;
            $display("FAIL midrst_inflight valid=%b count=%0d required 0/0", m_valid_a, u_a.u_buf.count_q);
        end
    endtask

    task automatic test_wrap();
        int n, ftx, ltx;
        rst_b = 1;
        repeat (2) step();
        rst_b = 0;
        for (int i = 0; i < 65537; i++) begin qb.push_back(8'(i)); expb.push_back(8'(i)); end
        rdy_b = 1;
        n = 0; ftx = -1; ltx = -1;
        while (n < 66000 && expb.size() != 0) begin
            step();
            n++;
            if (m_valid_b) begin
                if (ftx < 0) ftx = cyc;
                ltx = cyc;
            end
        end
        step();
        checks++;
        if (expb.size() != 0 || words_read_b !== 16'd1) begin
            errors++;
            $display("FAIL wrap left=%0d words=%0d required 0/1", expb.size(), words_read_b);
        end
        checks++;
        if (ltx - ftx != 65536) begin
            errors++;
            $display("FAIL wrap_throughput span=%0d required 65536", ltx - ftx);
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; rd_cnt_a = 0; rd_cnt_b = 0;
        rd_word_a = '0; rd_word_b = '0;
        dpb = '{8'd0, 8'd0, 8'd0};
        rst_a = 1; rst_b = 1; rdy_a = 0; rdy_b = 0; force_ne_a = 1; gate_a = 0;
        reset_a = 1; reset_b = 1; fifo_empty_a = 0; fifo_empty_b = 1;
        fifo_dout_a = '0; fifo_dout_b = '0; m_ready_a = 0; m_ready_b = 0;
        test_reset();
        test_basic(1'b0, 2, 4);
        test_backpressure();
        test_empty_boundary();
        test_reset_mid();
        test_basic(1'b1, 4, 4);
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
